// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: in-order byte-masked store queue between the write-mask generator and DMEM.
// Latency: a store accepted at edge N appears on mem_req_* in cycle N+1 when the queue was empty.
// Backpressure: st_ready low when full (no pass-through); head entry holds while mem_req_ready is low.
// Optional feature macro STORE_BUF_FWD_EN: forward a load word fully covered by queued stores.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_mask,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard,
    output logic             mem_req_valid,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_data,
    output logic [3:0]       mem_req_mask,
    input  logic             mem_req_ready,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             fwd_valid,
    output logic [31:0]      fwd_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_mask [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_mem_vld;
    logic w_enq;
    logic w_deq;
    logic w_ld_act;
    logic w_match;
    logic w_unused;

    // Byte offset bits never reach the queue or the compare.
    assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_mem_vld = (r_count != '0);
    // Zero-mask stores are handshaked but never occupy an entry.
    assign w_enq     = st_valid & ~w_full & (st_mask != 4'b0000);
    assign w_deq     = w_mem_vld & mem_req_ready;
    // A store in the same cycle wins; the illegal load is ignored.
    assign w_ld_act  = ld_valid & ~st_valid;

    assign st_ready      = ~w_full;
    assign empty         = ~w_mem_vld;
    assign count         = r_count;
    assign mem_req_valid = w_mem_vld;
    assign mem_req_addr  = {r_addr[r_rd_ptr], 2'b00};
    assign mem_req_data  = r_data[r_rd_ptr];
    assign mem_req_mask  = r_mask[r_rd_ptr];

    // Queue storage, pointers and occupancy; reset clears everything so mem_req_* read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_mask[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_addr[r_wr_ptr] <= st_addr[31:2];
                r_data[r_wr_ptr] <= st_data;
                r_mask[r_wr_ptr] <= st_mask;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [3:0]  w_cover;
    logic [31:0] w_merge;

    // Walk entries oldest to youngest so the youngest covering byte per lane wins.
    always_comb begin
        w_match = 1'b0;
        w_cover = '0;
        w_merge = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) &&
                (r_addr[r_rd_ptr + PTR_W'(k)] == ld_addr[31:2])) begin
                w_match = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    if (r_mask[r_rd_ptr + PTR_W'(k)][l]) begin
                        w_cover[l]        = 1'b1;
                        w_merge[8*l +: 8] = r_data[r_rd_ptr + PTR_W'(k)][8*l +: 8];
                    end
                end
            end
        end
    end

    assign fwd_valid = w_ld_act & w_match & (w_cover == 4'hF);
    assign fwd_data  = fwd_valid ? w_merge : 32'h0;
    assign ld_hazard = w_ld_act & w_match & (w_cover != 4'hF);
`else
    // Any live entry (head included) at the load's word address forces a stall.
    always_comb begin
        w_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) &&
                (r_addr[r_rd_ptr + PTR_W'(k)] == ld_addr[31:2])) begin
                w_match = 1'b1;
            end
        end
    end

    assign fwd_valid = 1'b0;
    assign fwd_data  = 32'h0;
    assign ld_hazard = w_ld_act & w_match;
`endif

endmodule
